keypad_scanner: RTL and testbench



---
 rtl/keypad_pkg.sv | 28 ++
 rtl/key_event_fifo.sv | 105 ++++++++++
 rtl/keypad_scanner.sv | 256 +++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared definitions for the matrix keypad scanner: key-code
//                width helper, "no key" code, event kind encodings and the
//                event FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  // Key code width: one "valid" MSB above a row*NCOLS+col index.
  function automatic int kw(input int nrows, input int ncols);
    return $clog2(nrows * ncols) + 1;
  endfunction

  localparam int KEY_NONE = 0;

  localparam logic EVT_KIND_PRESS   = 1'b1;
  localparam logic EVT_KIND_RELEASE = 1'b0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PUSH_REL = 2'd1,
    PUSH_PRS = 2'd2
  } ev_state_t;

endpackage
`default_nettype wire

// File: rtl/key_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_fifo
//  Description : Synchronous FIFO for key events with registered head outputs.
//                A push into a full FIFO succeeds only when a pop happens in
//                the same cycle; a pop while empty is ignored.
//  Ports       : clk, rst (sync, active-high)
//                push, push_data  - write side
//                pop              - remove head entry
//                full, empty      - occupancy flags
//                head_valid, head_data - registered head (data 0 when empty)
//  Revision    : 1.0 - initial release
// ============================================================================
module key_event_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_chk_depth
    $error("key_event_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    count_nxt  = count;
    rd_ptr_nxt = rd_ptr;
    if (do_push && !do_pop) begin
      count_nxt = count + CNT_ONE;
    end else if (!do_push && do_pop) begin
      count_nxt = count - CNT_ONE;
    end
    if (do_pop) begin
      rd_ptr_nxt = rd_ptr + PTR_ONE;
    end
  end

  // The next head may be the slot being written this very cycle (only
  // possible when the FIFO holds exactly one entry afterwards), so bypass
  // the incoming data in that case.
  always_comb begin
    head_nxt = '0;
    if (count_nxt != '0) begin
      if (do_push && (wr_ptr == rd_ptr_nxt)) begin
        head_nxt = push_data;
      end else begin
        head_nxt = mem[rd_ptr_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      rd_ptr     <= rd_ptr_nxt;
      count      <= count_nxt;
      head_valid <= (count_nxt != '0);
      head_data  <= head_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : Row/column matrix keypad scanner. Drives one-hot columns,
//                samples synchronised rows once per column slot, resolves one
//                key per frame (multi-key frames are ghosts), debounces across
//                frames and queues press/release events in a FIFO.
//  Ports       : CLK, RST (sync, active-high)
//                ROWS      - async row sense lines (pulled down)
//                COLS      - one-hot column drive
//                KEYCODE   - debounced key, {1'b1, row*NCOLS+col}; 0 = none
//                EVT_VALID/EVT_CODE/EVT_PRESS - registered event FIFO head
//                EVT_READY - pops the head when EVT_VALID is high
//                OVERFLOW  - sticky, an event was dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter  int NROWS    = 4,
  parameter  int NCOLS    = 4,
  parameter  int SCAN_DIV = 16000,
  parameter  int DEBOUNCE = 4,
  parameter  int DEPTH    = 4,
  localparam int KW       = kw(NROWS, NCOLS)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NROWS-1:0] ROWS,
  output logic [NCOLS-1:0] COLS,
  output logic [KW-1:0]    KEYCODE,
  output logic             EVT_VALID,
  output logic [KW-1:0]    EVT_CODE,
  output logic             EVT_PRESS,
  input  logic             EVT_READY,
  output logic             OVERFLOW
);

  localparam int IW = KW - 1;
  localparam int RW = $clog2(NROWS);
  localparam int CW = $clog2(NCOLS);
  localparam int SW = $clog2(SCAN_DIV);

  localparam logic [SW-1:0]    SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0]    SLOT_ONE  = SW'(1);
  localparam logic [CW-1:0]    COL_LAST  = CW'(NCOLS - 1);
  localparam logic [CW-1:0]    COL_ONE   = CW'(1);
  localparam logic [NCOLS-1:0] COL0_DRV  = NCOLS'(1);
  localparam logic [3:0]       DEB_MAX   = 4'(DEBOUNCE);
  localparam logic [KW-1:0]    CODE_NONE = KW'(KEY_NONE);

  // The event FSM needs at least two cycles between frame ends.
  if (SCAN_DIV < 2) begin : g_chk_scan_div
    $error("keypad_scanner: SCAN_DIV must be at least 2");
  end
  if ((DEBOUNCE < 1) || (DEBOUNCE > 15)) begin : g_chk_debounce
    $error("keypad_scanner: DEBOUNCE must be in 1..15");
  end
  if ((NROWS < 2) || (NROWS > 8) || (NCOLS < 2) || (NCOLS > 8)) begin : g_chk_matrix
    $error("keypad_scanner: NROWS and NCOLS must be in 2..8");
  end

  // ---------------------------------------------------------------- sync
  logic [NROWS-1:0] rows_meta;
  logic [NROWS-1:0] rows_sync;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rows_meta <= '0;
      rows_sync <= '0;
    end else begin
      rows_meta <= ROWS;
      rows_sync <= rows_meta;
    end
  end

  // ---------------------------------------------------------------- scan
  logic [SW-1:0] slot;
  logic [CW-1:0] col;
  logic          sample;
  logic          frame_end;

  assign sample    = (slot == SLOT_LAST);
  assign frame_end = sample && (col == COL_LAST);
  assign COLS      = COL0_DRV << col;

  always_ff @(posedge CLK) begin
    if (RST) begin
      slot <= '0;
      col  <= '0;
    end else if (sample) begin
      slot <= '0;
      col  <= frame_end ? '0 : col + COL_ONE;
    end else begin
      slot <= slot + SLOT_ONE;
    end
  end

  // ----------------------------------------------------- frame resolution
  // Hit counts saturate at 2: anything beyond one key is a ghost frame.
  logic [1:0]    col_hits;
  logic [RW-1:0] col_row;
  logic [IW-1:0] col_idx;
  logic [1:0]    acc_hits;
  logic [IW-1:0] acc_idx;
  logic [2:0]    hit_sum;
  logic [1:0]    tot_hits;
  logic [IW-1:0] tot_idx;
  logic [KW-1:0] frame_code;
  logic          frame_ghost;

  always_comb begin
    col_hits = 2'd0;
    col_row  = '0;
    for (int r = NROWS - 1; r >= 0; r--) begin
      if (rows_sync[r]) begin
        col_row = RW'(r);
        if (col_hits != 2'd2) begin
          col_hits = col_hits + 2'd1;
        end
      end
    end
  end

  assign col_idx     = IW'(int'(col_row) * NCOLS + int'(col));
  assign hit_sum     = {1'b0, acc_hits} + {1'b0, col_hits};
  assign tot_hits    = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
  assign tot_idx     = (acc_hits == 2'd0) ? col_idx : acc_idx;
  assign frame_code  = (tot_hits == 2'd1) ? {1'b1, tot_idx} : CODE_NONE;
  assign frame_ghost = (tot_hits == 2'd2);

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_hits <= 2'd0;
      acc_idx  <= '0;
    end else if (sample) begin
      if (frame_end) begin
        acc_hits <= 2'd0;
        acc_idx  <= '0;
      end else begin
        acc_hits <= tot_hits;
        acc_idx  <= tot_idx;
      end
    end
  end

  // ------------------------------------------------------------ debounce
  logic [KW-1:0] cand;
  logic [3:0]    cnt;
  logic [KW-1:0] stable;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cand   <= CODE_NONE;
      cnt    <= 4'd0;
      stable <= CODE_NONE;
    end else begin
      if (frame_end && !frame_ghost) begin
        if (frame_code == cand) begin
          if (cnt != DEB_MAX) begin
            cnt <= cnt + 4'd1;
          end
        end else begin
          cand <= frame_code;
          cnt  <= 4'd1;
        end
      end
      if ((cnt == DEB_MAX) && (cand != stable)) begin
        stable <= cand;
      end
    end
  end

  assign KEYCODE = stable;

  // ----------------------------------------------------------- event FSM
  // 'reported' is the key last announced to the consumer; a difference to
  // 'stable' starts a release and/or press push sequence.
  ev_state_t     state;
  ev_state_t     state_nxt;
  logic [KW-1:0] reported;
  logic          ev_push;
  logic [KW:0]   ev_data;

  always_comb begin
    state_nxt = state;
    ev_push   = 1'b0;
    ev_data   = '0;
    case (state)
      IDLE: begin
        if (stable != reported) begin
          state_nxt = (reported != CODE_NONE) ? PUSH_REL : PUSH_PRS;
        end
      end
      PUSH_REL: begin
        ev_push   = 1'b1;
        ev_data   = {EVT_KIND_RELEASE, reported};
        state_nxt = (stable != CODE_NONE) ? PUSH_PRS : IDLE;
      end
      PUSH_PRS: begin
        ev_push   = 1'b1;
        ev_data   = {EVT_KIND_PRESS, stable};
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      reported <= CODE_NONE;
    end else begin
      state <= state_nxt;
      if ((state != IDLE) && (state_nxt == IDLE)) begin
        reported <= stable;
      end
    end
  end

  // ---------------------------------------------------------------- FIFO
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;
  logic [KW:0] head_data;

  assign fifo_pop = EVT_READY && !fifo_empty;

  key_event_fifo #(
    .WIDTH (KW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (CLK),
    .rst        (RST),
    .push       (ev_push),
    .push_data  (ev_data),
    .pop        (fifo_pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head_valid (EVT_VALID),
    .head_data  (head_data)
  );

  assign EVT_PRESS = head_data[KW];
  assign EVT_CODE  = head_data[KW-1:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      OVERFLOW <= 1'b0;
    end else if (ev_push && fifo_full && !fifo_pop) begin
      OVERFLOW <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scanner
//  Description : Self-checking bench for keypad_scanner (4x4, SCAN_DIV=4,
//                DEBOUNCE=2, DEPTH=4). A keypad matrix model drives ROWS from
//                the set of held keys and COLS; a frame-level reference model
//                derives KEYCODE, the event stream and OVERFLOW.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  localparam int NR    = 4;
  localparam int NC    = 4;
  localparam int SD    = 4;
  localparam int DEB   = 2;
  localparam int DEP   = 4;
  localparam int KW    = 5;
  localparam int FRAME = NC * SD;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          EVT_READY = 1'b0;
  logic [NR-1:0] ROWS;
  logic [NC-1:0] COLS;
  logic [KW-1:0] KEYCODE;
  logic          EVT_VALID;
  logic [KW-1:0] EVT_CODE;
  logic          EVT_PRESS;
  logic          OVERFLOW;

  // Held keys, bit index = row*NC + col.
  logic [15:0]   pressed = '0;

  keypad_scanner #(
    .NROWS    (NR),
    .NCOLS    (NC),
    .SCAN_DIV (SD),
    .DEBOUNCE (DEB),
    .DEPTH    (DEP)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ROWS      (ROWS),
    .COLS      (COLS),
    .KEYCODE   (KEYCODE),
    .EVT_VALID (EVT_VALID),
    .EVT_CODE  (EVT_CODE),
    .EVT_PRESS (EVT_PRESS),
    .EVT_READY (EVT_READY),
    .OVERFLOW  (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  // A row reads high when any held key on it sits in a driven column.
  always_comb begin
    ROWS = '0;
    for (int r = 0; r < NR; r++) begin
      ROWS[r] = |(pressed[r*NC +: NC] & COLS);
    end
  end

  // Reference model state
  logic [4:0] hist[$];     // last DEB non-ghost frame results
  logic [4:0] stable_m;
  logic [5:0] exp_q[$];    // {press, code} expected in the FIFO
  logic       ovf_m;
  int         checks = 0;
  int         errors = 0;
  int         frame_pos = 0;
  int         pops = 0;
  bit         chk_cols = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
    stable_m = '0;
    ovf_m    = 1'b0;
  endtask

  task automatic model_push(input logic press, input logic [4:0] code);
    if (exp_q.size() < DEP) exp_q.push_back({press, code});
    else ovf_m = 1'b1;
  endtask

  // A key is accepted once the last DEB non-ghost frames all agree on it.
  task automatic model_frame_end(input logic [15:0] mask);
    int         n;
    logic [4:0] res;
    bit         same;
    n = $countones(mask);
    if (n >= 2) return;
    res = '0;
    for (int i = 0; i < 16; i++) if (mask[i]) res = {1'b1, 4'(i)};
    hist.push_back(res);
    if (hist.size() > DEB) void'(hist.pop_front());
    if (hist.size() == DEB) begin
      same = 1'b1;
      foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
      if (same && (hist[0] != stable_m)) begin
        if (stable_m != '0) model_push(1'b0, stable_m);
        if (hist[0] != '0)  model_push(1'b1, hist[0]);
        stable_m = hist[0];
      end
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step();
    logic [5:0] e;
    if (EVT_VALID && EVT_READY) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", 32'(EVT_VALID), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("evt_code", 32'(EVT_CODE), 32'(e[4:0]));
        check("evt_press", 32'(EVT_PRESS), 32'(e[5]));
        pops++;
      end
    end
    if (chk_cols) check("cols", 32'(COLS), 32'(1 << (frame_pos / SD)));
    if (frame_pos == FRAME / 2) begin
      check("keycode", 32'(KEYCODE), 32'(stable_m));
      check("overflow", 32'(OVERFLOW), 32'(ovf_m));
      check("evt_valid", 32'(EVT_VALID), 32'(exp_q.size() != 0));
      if (exp_q.size() == 0) begin
        check("evt_code_idle", 32'(EVT_CODE), 32'd0);
        check("evt_press_idle", 32'(EVT_PRESS), 32'd0);
      end
    end
    if (frame_pos == FRAME - 1) model_frame_end(pressed);
    frame_pos = (frame_pos + 1) % FRAME;
    @(negedge CLK);
  endtask

  task automatic run_frames(input logic [15:0] mask, input int n);
    repeat (n) begin
      pressed = mask;
      repeat (FRAME) step();
    end
  endtask

  task automatic do_reset();
    pressed = '0;
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("rst_cols", 32'(COLS), 32'd1);
    check("rst_keycode", 32'(KEYCODE), 32'd0);
    check("rst_evt_valid", 32'(EVT_VALID), 32'd0);
    check("rst_evt_code", 32'(EVT_CODE), 32'd0);
    check("rst_evt_press", 32'(EVT_PRESS), 32'd0);
    check("rst_overflow", 32'(OVERFLOW), 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    frame_pos = 0;
  endtask

  initial begin
    int p0;
    int k1;
    int k2;
    model_reset();

    // Reset and idle scanning
    do_reset();
    EVT_READY = 1'b1;
    chk_cols  = 1'b1;
    run_frames(16'h0000, 10);
    chk_cols  = 1'b0;

    // Single key row 1 / col 2 (0x16): press then release
    p0 = pops;
    run_frames(16'h0040, 2);
    repeat (FRAME / 2) step();
    check("keycode_16", 32'(KEYCODE), 32'h16);
    repeat (FRAME / 2) step();
    run_frames(16'h0000, 3);
    check("press_release_pops", 32'(pops - p0), 32'd2);

    // Bounce: never two matching frames in a row
    p0 = pops;
    run_frames(16'h0040, 1);
    run_frames(16'h0000, 1);
    run_frames(16'h0040, 1);
    run_frames(16'h0000, 2);
    check("bounce_pops", 32'(pops - p0), 32'd0);
    check("bounce_keycode", 32'(KEYCODE), 32'd0);

    // Slide 0x11 -> 0x1A -> none
    p0 = pops;
    run_frames(16'h0002, 3);
    run_frames(16'h0400, 3);
    run_frames(16'h0000, 3);
    check("slide_pops", 32'(pops - p0), 32'd4);

    // Ghost while 0x10 is stable
    run_frames(16'h0001, 3);
    p0 = pops;
    run_frames(16'h0021, 4);
    check("ghost_keycode", 32'(KEYCODE), 32'h10);
    run_frames(16'h0001, 2);
    check("ghost_pops", 32'(pops - p0), 32'd0);
    run_frames(16'h0000, 3);

    // Randomised key patterns: none, single keys and ghost pairs
    repeat (30) begin
      int kind;
      logic [15:0] m;
      kind = int'($urandom_range(0, 3));
      k1   = int'($urandom_range(0, 15));
      k2   = (k1 + 1 + int'($urandom_range(0, 14))) % 16;
      m    = '0;
      if (kind != 0) m[k1] = 1'b1;
      if (kind == 3) m[k2] = 1'b1;
      run_frames(m, int'($urandom_range(1, 3)));
    end
    run_frames(16'h0000, 3);

    // Overflow: six events with nobody popping
    EVT_READY = 1'b0;
    p0 = pops;
    run_frames(16'h0008, 2);
    run_frames(16'h0000, 2);
    run_frames(16'h0080, 2);
    run_frames(16'h0000, 2);
    run_frames(16'h1000, 2);
    run_frames(16'h0000, 3);
    check("ovf_set", 32'(OVERFLOW), 32'd1);
    check("ovf_queued_valid", 32'(EVT_VALID), 32'd1);
    EVT_READY = 1'b1;
    run_frames(16'h0000, 2);
    check("drain_pops", 32'(pops - p0), 32'd4);
    check("drain_valid", 32'(EVT_VALID), 32'd0);
    check("ovf_sticky", 32'(OVERFLOW), 32'd1);

    // Reset clears the sticky overflow
    do_reset();
    run_frames(16'h0000, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
